// File: rtl/xbar_pipe_if.sv
// Crossbar bus bundle: per-input flits with one-hot steering, per-output
// registered flits, plus stall / error-clear controls and status outputs.
interface xbar_pipe_if #(
   parameter int NUM_PORT     = 5,
   parameter int LOG_NUM_PORT = 3,
   parameter int DATA_WIDTH   = 64,
   parameter int CNT_WIDTH    = 8
) ();
   logic [NUM_PORT-1:0]              in_valid;
   logic [NUM_PORT*NUM_PORT-1:0]     in_ppv;
   logic [NUM_PORT*DATA_WIDTH-1:0]   in_data;
   logic                             stall;
   logic                             err_clr;
   logic [NUM_PORT-1:0]              out_valid;
   logic [NUM_PORT*DATA_WIDTH-1:0]   out_data;
   logic [NUM_PORT*LOG_NUM_PORT-1:0] out_src;
   logic                             conflict;
   logic                             err_sticky;
   logic [CNT_WIDTH-1:0]             drop_cnt;

   // Upstream side: drives flits and controls, observes switched outputs.
   modport master (
      output in_valid, in_ppv, in_data, stall, err_clr,
      input  out_valid, out_data, out_src, conflict, err_sticky, drop_cnt
   );

   // Crossbar side.
   modport slave (
      input  in_valid, in_ppv, in_data, stall, err_clr,
      output out_valid, out_data, out_src, conflict, err_sticky, drop_cnt
   );
endinterface

// File: rtl/xbar_pipe.sv
// N-port crossbar with one-hot steering, lowest-index-wins arbitration per
// output, registered outputs, sticky bad-steering flag and saturating drop count.
module xbar_pipe #(
   parameter int NUM_PORT     = 5,
   parameter int LOG_NUM_PORT = 3,
   parameter int DATA_WIDTH   = 64,
   parameter int CNT_WIDTH    = 8
) (
   input logic        clk,
   input logic        reset,
   xbar_pipe_if.slave xbar
);
   localparam logic [LOG_NUM_PORT:0] DROP_ONE = {{LOG_NUM_PORT{1'b0}}, 1'b1};

   logic [NUM_PORT-1:0]              r_out_valid;
   logic [NUM_PORT*DATA_WIDTH-1:0]   r_out_data;
   logic [NUM_PORT*LOG_NUM_PORT-1:0] r_out_src;
   logic                             r_conflict;
   logic                             r_err_sticky;
   logic [CNT_WIDTH-1:0]             r_drop_cnt;

   logic [NUM_PORT-1:0]              w_ok;
   logic [NUM_PORT-1:0]              w_valid;
   logic [NUM_PORT*DATA_WIDTH-1:0]   w_data;
   logic [NUM_PORT*LOG_NUM_PORT-1:0] w_src;
   logic                             w_conflict;
   logic                             w_bad;
   // Drops per cycle never exceed NUM_PORT, so one extra bit over a port index suffices.
   logic [LOG_NUM_PORT:0]            w_drops;
   logic [CNT_WIDTH:0]               w_cnt_sum;
   logic [CNT_WIDTH-1:0]             w_cnt_next;

   // Validate steering vectors, then pick the lowest-index requester per output.
   always_comb begin
      w_ok       = '0;
      w_valid    = '0;
      w_data     = '0;
      w_src      = '0;
      w_conflict = 1'b0;
      w_bad      = 1'b0;
      w_drops    = '0;
      for (int i = 0; i < NUM_PORT; i++) begin
         w_ok[i] = xbar.in_valid[i] && $onehot(xbar.in_ppv[i*NUM_PORT +: NUM_PORT]);
         if (xbar.in_valid[i] && !w_ok[i]) begin
            w_bad   = 1'b1;
            w_drops = w_drops + DROP_ONE;
         end
      end
      for (int j = 0; j < NUM_PORT; j++) begin
         for (int i = 0; i < NUM_PORT; i++) begin
            if (w_ok[i] && xbar.in_ppv[i*NUM_PORT + j]) begin
               if (!w_valid[j]) begin
                  w_valid[j]                         = 1'b1;
                  w_data[j*DATA_WIDTH +: DATA_WIDTH] = xbar.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                  w_src[j*LOG_NUM_PORT +: LOG_NUM_PORT] = LOG_NUM_PORT'(i);
               end else begin
                  w_conflict = 1'b1;
                  w_drops    = w_drops + DROP_ONE;
               end
            end
         end
      end
      // One guard bit catches overflow; saturate instead of wrapping.
      w_cnt_sum  = {1'b0, r_drop_cnt} + (CNT_WIDTH+1)'(w_drops);
      w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
   end

   // Output stage: load on non-stalled cycles; err_clr acts even under stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= '0;
         r_out_data   <= '0;
         r_out_src    <= '0;
         r_conflict   <= 1'b0;
         r_err_sticky <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         if (!xbar.stall) begin
            r_out_valid <= w_valid;
            r_out_data  <= w_data;
            r_out_src   <= w_src;
            r_conflict  <= w_conflict;
            r_drop_cnt  <= w_cnt_next;
         end
         if (!xbar.stall && w_bad) begin
            r_err_sticky <= 1'b1;
         end else if (xbar.err_clr) begin
            r_err_sticky <= 1'b0;
         end
      end
   end

   assign xbar.out_valid  = r_out_valid;
   assign xbar.out_data   = r_out_data;
   assign xbar.out_src    = r_out_src;
   assign xbar.conflict   = r_conflict;
   assign xbar.err_sticky = r_err_sticky;
   assign xbar.drop_cnt   = r_drop_cnt;
endmodule

// File: tb/tb_xbar_pipe.sv
// Randomised bench for xbar_pipe against a behavioural crossbar model, plus
// literal expectations for the directed scenarios.
module tb_xbar_pipe;
   localparam int NP = 5;
   localparam int LP = 3;
   localparam int DW = 16;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset;

   xbar_pipe_if #(.NUM_PORT(NP), .LOG_NUM_PORT(LP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   xbar_pipe #(.NUM_PORT(NP), .LOG_NUM_PORT(LP), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk  (clk),
      .reset(reset),
      .xbar (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Applied stimulus (what the DUT samples on the next edge).
   logic [NP-1:0]    s_valid;
   logic [NP*NP-1:0] s_ppv;
   logic [NP*DW-1:0] s_data;
   logic             s_stall, s_clr, s_reset;

   // Model state.
   bit        m_valid[NP];
   bit [15:0] m_data[NP];
   int        m_src[NP];
   bit        m_conf, m_err;
   int        m_cnt;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic [NP-1:0] v, input logic [NP*NP-1:0] p,
                        input logic [NP*DW-1:0] d, input logic st, input logic cl,
                        input logic rs);
      s_valid = v; s_ppv = p; s_data = d; s_stall = st; s_clr = cl; s_reset = rs;
      bus.in_valid = v; bus.in_ppv = p; bus.in_data = d;
      bus.stall = st; bus.err_clr = cl; reset = rs;
   endtask

   // Behavioural next state: count requesters per output, first one wins.
   task automatic model_update();
      int drops;
      bit bad;
      if (s_reset) begin
         for (int j = 0; j < NP; j++) begin
            m_valid[j] = 0; m_data[j] = 0; m_src[j] = 0;
         end
         m_conf = 0; m_err = 0; m_cnt = 0;
         return;
      end
      if (s_stall) begin
         if (s_clr) m_err = 0;
         return;
      end
      drops = 0; bad = 0; m_conf = 0;
      for (int i = 0; i < NP; i++)
         if (s_valid[i] && $countones(s_ppv[i*NP +: NP]) != 1) begin
            bad = 1; drops++;
         end
      for (int j = 0; j < NP; j++) begin
         int reqs[$];
         for (int i = 0; i < NP; i++)
            if (s_valid[i] && $countones(s_ppv[i*NP +: NP]) == 1 && s_ppv[i*NP + j])
               reqs.push_back(i);
         m_valid[j] = reqs.size() > 0;
         m_data[j]  = m_valid[j] ? s_data[reqs[0]*DW +: DW] : 16'h0;
         m_src[j]   = m_valid[j] ? reqs[0] : 0;
         if (reqs.size() > 1) begin
            m_conf = 1;
            drops += reqs.size() - 1;
         end
      end
      m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
      if (bad) m_err = 1;
      else if (s_clr) m_err = 0;
   endtask

   // One clock: advance model, then compare every output against it.
   task automatic step();
      logic [NP-1:0]    ev;
      logic [NP*DW-1:0] ed;
      logic [NP*LP-1:0] es;
      @(posedge clk);
      #1;
      model_update();
      for (int j = 0; j < NP; j++) begin
         ev[j]            = m_valid[j];
         ed[j*DW +: DW]   = m_data[j];
         es[j*LP +: LP]   = LP'(m_src[j]);
      end
      chk("out_valid", 128'(bus.out_valid), 128'(ev));
      chk("out_data", 128'(bus.out_data), 128'(ed));
      chk("out_src", 128'(bus.out_src), 128'(es));
      chk("conflict", 128'(bus.conflict), 128'(m_conf));
      chk("err_sticky", 128'(bus.err_sticky), 128'(m_err));
      chk("drop_cnt", 128'(bus.drop_cnt), 128'(m_cnt));
   endtask

   logic [NP*NP-1:0] ppv;
   logic [NP*DW-1:0] dat;

   initial begin
      drive('0, '0, '0, 1'b0, 1'b0, 1'b1);

      // Reset with all inputs valid and ppv all-ones.
      drive('1, '1, '1, 1'b0, 1'b0, 1'b1);
      step();
      step();
      chk("rst_valid", 128'(bus.out_valid), 128'h0);
      chk("rst_data", 128'(bus.out_data), 128'h0);
      chk("rst_src", 128'(bus.out_src), 128'h0);
      chk("rst_flags", 128'({bus.conflict, bus.err_sticky}), 128'h0);
      chk("rst_cnt", 128'(bus.drop_cnt), 128'h0);

      // Permutation i -> (i+1)%5.
      ppv = '0; dat = '0;
      for (int i = 0; i < NP; i++) begin
         ppv[i*NP + (i+1)%NP] = 1'b1;
         dat[i*DW +: DW] = 16'(16'hA0 + i);
      end
      drive('1, ppv, dat, 1'b0, 1'b0, 1'b0);
      step();
      chk("perm_valid", 128'(bus.out_valid), 128'h1f);
      for (int i = 0; i < NP; i++) begin
         chk("perm_data", 128'(bus.out_data[((i+1)%NP)*DW +: DW]), 128'(16'hA0 + i));
         chk("perm_src", 128'(bus.out_src[((i+1)%NP)*LP +: LP]), 128'(i));
      end
      chk("perm_conf", 128'(bus.conflict), 128'h0);
      chk("perm_cnt", 128'(bus.drop_cnt), 128'h0);

      // Inputs 1 and 3 both to output 2.
      ppv = '0; dat = '0;
      ppv[1*NP + 2] = 1'b1; ppv[3*NP + 2] = 1'b1;
      dat[1*DW +: DW] = 16'h1111; dat[3*DW +: DW] = 16'h3333;
      drive(5'b01010, ppv, dat, 1'b0, 1'b0, 1'b0);
      step();
      chk("conf_valid", 128'(bus.out_valid), 128'h04);
      chk("conf_data", 128'(bus.out_data[2*DW +: DW]), 128'h1111);
      chk("conf_src", 128'(bus.out_src[2*LP +: LP]), 128'h1);
      chk("conf_flag", 128'(bus.conflict), 128'h1);
      chk("conf_cnt", 128'(bus.drop_cnt), 128'h1);

      // Bad ppv, then err_clr racing a second bad ppv, then err_clr alone.
      ppv = '0; ppv[4:0] = 5'b00110;
      drive(5'b00001, ppv, '0, 1'b0, 1'b0, 1'b0);
      step();
      chk("bad_valid", 128'(bus.out_valid), 128'h0);
      chk("bad_err", 128'(bus.err_sticky), 128'h1);
      chk("bad_cnt", 128'(bus.drop_cnt), 128'h2);
      drive(5'b00001, ppv, '0, 1'b0, 1'b1, 1'b0);
      step();
      chk("bad_clr_race", 128'(bus.err_sticky), 128'h1);
      chk("bad_cnt2", 128'(bus.drop_cnt), 128'h3);
      drive('0, '0, '0, 1'b0, 1'b1, 1'b0);
      step();
      chk("clr_err", 128'(bus.err_sticky), 128'h0);

      // Load 0xBEEF on output 4, then stall with everyone aimed at output 0.
      ppv = '0; dat = '0;
      ppv[4*NP + 4] = 1'b1; dat[4*DW +: DW] = 16'hBEEF;
      drive(5'b10000, ppv, dat, 1'b0, 1'b0, 1'b0);
      step();
      chk("beef_load", 128'(bus.out_data[4*DW +: DW]), 128'hBEEF);
      ppv = '0; dat = '0;
      for (int i = 0; i < NP; i++) begin
         ppv[i*NP] = 1'b1;
         dat[i*DW +: DW] = 16'(16'h1000 + i);
      end
      for (int k = 0; k < 3; k++) begin
         drive('1, ppv, dat, 1'b1, 1'b0, 1'b0);
         step();
         chk("stall_hold", 128'(bus.out_data[4*DW +: DW]), 128'hBEEF);
         chk("stall_valid", 128'(bus.out_valid), 128'h10);
         chk("stall_cnt", 128'(bus.drop_cnt), 128'h3);
      end
      drive('1, ppv, dat, 1'b0, 1'b0, 1'b0);
      step();
      chk("unstall_data", 128'(bus.out_data[0 +: DW]), 128'h1000);
      chk("unstall_src", 128'(bus.out_src[0 +: LP]), 128'h0);
      chk("unstall_cnt", 128'(bus.drop_cnt), 128'h7);

      // Saturation from a fresh reset.
      drive('0, '0, '0, 1'b0, 1'b0, 1'b1);
      step();
      for (int k = 1; k <= 70; k++) begin
         drive('1, ppv, dat, 1'b0, 1'b0, 1'b0);
         step();
         if (k == 63) chk("sat_252", 128'(bus.drop_cnt), 128'd252);
         if (k == 64) chk("sat_255", 128'(bus.drop_cnt), 128'd255);
      end
      chk("sat_hold", 128'(bus.drop_cnt), 128'd255);

      // Random traffic: mostly one-hot steering, some junk, stalls, clears, resets.
      for (int k = 0; k < 400; k++) begin
         logic [NP-1:0] v;
         v = NP'($urandom);
         for (int i = 0; i < NP; i++) begin
            if ($urandom_range(0, 9) < 8) ppv[i*NP +: NP] = NP'(1 << $urandom_range(0, NP-1));
            else ppv[i*NP +: NP] = NP'($urandom);
            dat[i*DW +: DW] = 16'($urandom);
         end
         drive(v, ppv, dat, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 49) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/xbar_pipe.md
# xbar_pipe

Parametrised N-port crossbar with one-hot steering, output conflict resolution and a registered output stage. It is the next-generation replacement for the fixed 5-port combinational switch in the router datapath, sitting between port allocation and the link output registers. Any port count is supported. Protocol violations (invalid steering vectors, two inputs targeting one output) are detected and counted instead of producing undefined muxing.

## Interface
- NUM_PORT, 5, number of input and output ports (≥2)
- LOG_NUM_PORT, 3, width of a port index; must equal ceil(log2(NUM_PORT))
- DATA_WIDTH, 64, flit width in bits
- CNT_WIDTH, 8, width of the saturating drop counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_PORT  bit i: input i carries a flit this cycle
- in_ppv  in  NUM_PORT*NUM_PORT  slice [i*NUM_PORT +: NUM_PORT] is the one-hot output vector of input i
- in_data  in  NUM_PORT*DATA_WIDTH  slice [i*DATA_WIDTH +: DATA_WIDTH] is the flit of input i
- stall  in  1  hold all output registers and ignore inputs
- err_clr  in  1  clear err_sticky
- out_valid  out  NUM_PORT  bit j: output j carries a flit
- out_data  out  NUM_PORT*DATA_WIDTH  flit on output j; all-zero when out_valid[j]=0
- out_src  out  NUM_PORT*LOG_NUM_PORT  index of the input that won output j; 0 when invalid
- conflict  out  1  at least one output had more than one requester in the cycle now presented
- err_sticky  out  1  set by any valid input carrying a non-one-hot in_ppv
- drop_cnt  out  CNT_WIDTH  saturating count of dropped flits

## Operation
- **Request formation:** input i requests output j only if in_valid[i]=1, in_ppv slice i is exactly one-hot, and bit j is set.
  - in_ppv of an input with in_valid=0 is ignored.
- **Bad steering vector:** a valid input with a zero or multi-bit ppv is dropped. It sets err_sticky and counts as one drop.
- **Arbitration per output:** the lowest-index requesting input wins.
  - Each losing requester is dropped and counts as one drop.
  - conflict is registered as 1 when any output has two or more requesters.
- **Output register load:** when stall=0, each output register loads:
  - out_valid[j] = (any requester for j)
  - out_data[j] = winner's data, else zero
  - out_src[j] = winner's index, else zero
- **Drop counter:** drop_cnt += (number of drops this cycle), computed at full width, then saturated at 2^CNT_WIDTH−1. It never wraps.
- **Stall:** when stall=1, all of the following hold their values, and inputs are neither switched nor counted (upstream must hold its flits):
  - out_valid, out_data, out_src
  - conflict
  - drop_cnt
  - err_sticky (except for the err_clr rule below)
- **err_sticky update:**
  - err_clr=1 clears err_sticky on the next edge, whether or not stall is asserted.
  - If a new bad ppv arrives in the same cycle with stall=0, set wins and err_sticky stays 1.
- **Reset:** all outputs are 0 on the cycle after reset is sampled high.
  - Reset overrides stall and err_clr.
  - Flits in flight are discarded and are not counted.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- There is no combinational path from any input to any output.
- Throughput is one flit per output per cycle when stall=0.
- conflict, drop_cnt and err_sticky update on the same edge as the data they describe.
- conflict is a single-cycle indication; it is not sticky.
- Simultaneous conflict and bad ppv in one cycle: both are counted, e.g. one conflict loser plus one bad-ppv flit gives drop_cnt +2.

## Test plan
All scenarios use NUM_PORT=5, DATA_WIDTH=16, CNT_WIDTH=8.
- **Reset:** reset high for 2 cycles with all inputs valid and in_ppv all-ones -> out_valid=0, out_data=0, out_src=0, conflict=0, err_sticky=0, drop_cnt=0.
- **Permutation:** input i valid, data 0xA0+i, ppv one-hot to output (i+1)%5 -> next cycle out_valid=5'b11111, out_data[(i+1)%5]=0xA0+i, out_src[(i+1)%5]=i, conflict=0, drop_cnt unchanged.
- **Conflict:** inputs 1 (0x1111) and 3 (0x3333) both target output 2 -> out_valid=5'b00100, out_data[2]=0x1111, out_src[2]=1, conflict=1, drop_cnt 0->1.
- **Bad ppv and err_clr:**
  - Input 0 valid with ppv 5'b00110 -> out_valid=0, err_sticky=1, drop_cnt +1.
  - err_clr together with a second bad ppv -> err_sticky stays 1.
  - err_clr alone -> err_sticky=0 next cycle.
- **Stall:**
  - Load 0xBEEF on output 4, then assert stall for 3 cycles with all inputs requesting output 0 -> outputs hold 0xBEEF on output 4 and drop_cnt is unchanged.
  - Deassert stall -> output 0 = input 0's data, drop_cnt +4.
- **Saturation:** all 5 inputs target output 0 for 70 cycles -> drop_cnt rises by 4 per cycle, reaches 252 after 63 cycles, then holds at 255; it never wraps to 0.
